serial_latch_rx: RTL and testbench

//  Receiving end of the Ser/SClk/LClk shift-register link that our ADC/DAC drivers transmit on.

---
 rtl/pmod_link_pkg.sv | 13 +
 rtl/sync_rise_det.sv | 34 +++
 rtl/serial_latch_rx.sv | 108 ++++++++++
 tb/tb_serial_latch_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_link_pkg.sv
// Shared definitions for the Ser/SClk/LClk shift-register link.
// Both the ADC/DAC serial drivers and the receiver import this package.
package pmod_link_pkg;

    localparam int LINK_WIDTH       = 16;
    localparam int LINK_SYNC_STAGES = 2;

    // Bit-counter width: one bit of headroom above WIDTH so overlong frames stay distinguishable.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1) + 1;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for one asynchronous link wire, plus a rising-edge detector.
// A pin that is already high when reset releases is not reported as a rise.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   arm_q;

    // arm_q fills with ones after reset.
    // Rises are ignored until the synchronizer and prev flop both hold post-reset pin samples.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            arm_q  <= {arm_q[STAGES-1:0], 1'b1};
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q & arm_q[STAGES];

endmodule

// File: rtl/serial_latch_rx.sv
// Receiver for the Ser/SClk/LClk link.
// Shifts Ser in MSB-first on SClk rises and latches the frame to a valid/ready output on LClk rises.
module serial_latch_rx
    import pmod_link_pkg::*;
#(
    parameter int WIDTH       = LINK_WIDTH,
    parameter int SYNC_STAGES = LINK_SYNC_STAGES,
    parameter int CW          = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ser_i,
    input  logic             sclk_i,
    input  logic             lclk_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic [CW-1:0]    bit_cnt_o
);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_FRAME = CW'(WIDTH);

    logic             ser_sync;
    logic             ser_rise_unused;
    logic             sclk_sync;
    logic             sclk_rise;
    logic             lclk_sync;
    logic             lclk_rise;
    logic [WIDTH-1:0] shreg_q;

    // Ser goes through the same synchronizer depth as SClk, so their relative skew is preserved.
    sync_rise_det #(.STAGES(SYNC_STAGES)) u_sync_ser (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (ser_i),
        .q_o     (ser_sync),
        .rise_o  (ser_rise_unused)
    );

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (sclk_i),
        .q_o     (sclk_sync),
        .rise_o  (sclk_rise)
    );

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_sync_lclk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (lclk_i),
        .q_o     (lclk_sync),
        .rise_o  (lclk_rise)
    );

    // The shift register is never cleared on latch.
    // A short frame leaves stale upper bits, as a 74HC595 does.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= '0;
        end else if (sclk_rise) begin
            shreg_q <= {shreg_q[WIDTH-2:0], ser_sync};
        end
    end

    // When a latch and a shift land in the same cycle, the latch takes the pre-shift word.
    // The new bit then becomes the first bit of the next frame.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bit_cnt_o <= '0;
        end else if (lclk_rise) begin
            bit_cnt_o <= sclk_rise ? CW'(1) : '0;
        end else if (sclk_rise && (bit_cnt_o != CNT_MAX)) begin
            bit_cnt_o <= bit_cnt_o + 1'b1;
        end
    end

    // A latch in the same cycle as a consume keeps valid high with the new frame, and there is no overrun.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (lclk_rise) begin
                data_o      <= shreg_q;
                frame_err_o <= (bit_cnt_o != CNT_FRAME);
                valid_o     <= 1'b1;
                overrun_o   <= valid_o & ~ready_i;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    // Kept for debug visibility at the synchronizer outputs.
    logic link_idle;
    assign link_idle = ~sclk_sync & ~lclk_sync;

    logic link_idle_unused;
    assign link_idle_unused = link_idle;

endmodule

// File: tb/tb_serial_latch_rx.sv
// Directed testbench for serial_latch_rx: frame shifting, short/long frames, same-cycle shift+latch,
// overrun, reset, counter saturation, and a model-checked run of random frames.
module tb_serial_latch_rx;
    import pmod_link_pkg::*;

    localparam int W  = LINK_WIDTH;
    localparam int CW = cnt_width(W);

    logic          clk = 1'b0;
    logic          reset;
    logic          ser;
    logic          sclk;
    logic          lclk;
    logic          ready;
    logic [W-1:0]  data;
    logic          valid;
    logic          ferr;
    logic          ovr;
    logic [CW-1:0] bcnt;

    int            n_cmp = 0;
    int            n_err = 0;
    int            ovr_cycles = 0;
    logic [W-1:0]  got_q[$];
    logic [W-1:0]  exp_q[$];

    serial_latch_rx dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .ser_i       (ser),
        .sclk_i      (sclk),
        .lclk_i      (lclk),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .bit_cnt_o   (bcnt)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after a rising edge.
    // Sampling at the falling edge therefore sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (ovr) ovr_cycles++;
        if (valid && ready && !reset) got_q.push_back(data);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser = v[i];
            step(2);
            sclk = 1'b1;
            step(2);
            sclk = 1'b0;
            step(1);
        end
    endtask

    task automatic latch();
        lclk = 1'b1;
        step(3);
        lclk = 1'b0;
        step(3);
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] pend_word;
        logic         pend;
        logic         r;
        int           o0;
        int           dropped;

        reset = 1'b1;
        ser   = 1'b0;
        sclk  = 1'b0;
        lclk  = 1'b0;
        ready = 1'b1;
        step(3);
        chk("rst_data", 32'(data), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_ovr", 32'(ovr), 0);
        chk("rst_bcnt", 32'(bcnt), 0);
        reset = 1'b0;
        step(2);

        // Full frame, checking latch latency edge by edge.
        send_bits(64'h2A52, 16);
        chk("f1_bcnt_pre", 32'(bcnt), 16);
        lclk = 1'b1;
        step(1);
        chk("f1_valid_e1", 32'(valid), 0);
        step(1);
        chk("f1_valid_e2", 32'(valid), 0);
        step(1);
        chk("f1_valid_e3", 32'(valid), 1);
        chk("f1_data", 32'(data), 32'h2A52);
        chk("f1_ferr", 32'(ferr), 0);
        chk("f1_bcnt", 32'(bcnt), 0);
        step(1);
        chk("f1_consumed", 32'(valid), 0);
        lclk = 1'b0;
        step(3);

        // Short frame keeps stale upper bits; a long frame keeps its last 16 bits.
        send_bits(64'hABC, 12);
        latch();
        chk("short_data", 32'(data), 32'h2ABC);
        chk("short_ferr", 32'(ferr), 1);
        send_bits(64'h51357, 20);
        chk("long_bcnt", 32'(bcnt), 20);
        latch();
        chk("long_data", 32'(data), 32'h1357);
        chk("long_ferr", 32'(ferr), 1);

        // The 17th bit's shift coincides with the latch.
        send_bits(64'hC3A5, 16);
        ser = 1'b1;
        step(2);
        sclk = 1'b1;
        lclk = 1'b1;
        step(3);
        chk("same_data", 32'(data), 32'hC3A5);
        chk("same_ferr", 32'(ferr), 0);
        chk("same_bcnt", 32'(bcnt), 1);
        sclk = 1'b0;
        lclk = 1'b0;
        step(3);
        latch();
        chk("same_next_data", 32'(data), 32'h874B);
        chk("same_next_ferr", 32'(ferr), 1);

        // Overrun with the consumer stalled.
        ready = 1'b0;
        step(1);
        o0 = ovr_cycles;
        send_bits(64'h0001, 16);
        latch();
        chk("ovr_f1_valid", 32'(valid), 1);
        chk("ovr_f1_data", 32'(data), 32'h0001);
        chk("ovr_f1_cnt", 32'(ovr_cycles - o0), 0);
        send_bits(64'hFFFF, 16);
        latch();
        chk("ovr_f2_data", 32'(data), 32'hFFFF);
        chk("ovr_f2_valid", 32'(valid), 1);
        chk("ovr_f2_ferr", 32'(ferr), 0);
        chk("ovr_pulse_cycles", 32'(ovr_cycles - o0), 1);
        ready = 1'b1;
        step(1);
        chk("ovr_consume", 32'(valid), 0);

        // Reset mid-frame with LClk held high across the release.
        send_bits(64'hA5, 8);
        reset = 1'b1;
        lclk  = 1'b1;
        step(2);
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_ferr", 32'(ferr), 0);
        chk("mid_rst_ovr", 32'(ovr), 0);
        chk("mid_rst_bcnt", 32'(bcnt), 0);
        reset = 1'b0;
        step(6);
        chk("no_edge_at_release", 32'(valid), 0);
        lclk = 1'b0;
        step(3);
        send_bits(64'h1234, 16);
        chk("post_rst_bcnt", 32'(bcnt), 16);
        latch();
        chk("post_rst_data", 32'(data), 32'h1234);
        chk("post_rst_ferr", 32'(ferr), 0);

        // Bit-count saturation.
        send_bits(64'h0, 40);
        send_bits(64'h0, 30);
        chk("sat_bcnt", 32'(bcnt), (1 << CW) - 1);
        latch();
        chk("sat_ferr", 32'(ferr), 1);
        chk("sat_bcnt_clr", 32'(bcnt), 0);

        // Random frames with random ready; ready is held constant across each frame.
        got_q.delete();
        exp_q.delete();
        pend      = 1'b0;
        pend_word = '0;
        dropped   = 0;
        o0        = ovr_cycles;
        for (int f = 0; f < 10; f++) begin
            r = 1'($urandom_range(0, 1));
            w = W'($urandom);
            ready = r;
            if (r && pend) begin
                exp_q.push_back(pend_word);
                pend = 1'b0;
            end
            send_bits(64'(w), W);
            latch();
            if (pend) begin
                dropped++;
                pend_word = w;
            end else if (r) begin
                exp_q.push_back(w);
            end else begin
                pend      = 1'b1;
                pend_word = w;
            end
        end
        ready = 1'b1;
        if (pend) exp_q.push_back(pend_word);
        step(3);
        chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("rand_word_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk("rand_overruns", 32'(ovr_cycles - o0), 32'(dropped));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
